// File: rtl/dpi_stream_feeder.sv
// dpi_stream_feeder
//   Transmit-side driver for the per-category regex matchers.
//   - Takes 32-bit packet words with sop/eop framing.
//   - Maps each packet's flow key to a 6-bit stream id through a 64-entry
//     flow table.
//   - Issues the load_state / stream_id / new_stream_id / enable handshake.
//   - Serializes the payload one byte per cycle, most significant byte first.
//   - Closes each packet with a single-cycle eop strobe.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   in_key/in_data/in_valid/in_sop/in_eop/in_last_bytes, in_ready
//                           ingress word stream; in_last_bytes == 0 means 4
//   cfg_we/cfg_sid/cfg_mask per-stream category enable mask write port
//   load_state, new_stream_id, stream_id, enable
//                           matcher state-restore handshake
//   char_in, char_in_vld, eop
//                           payload byte stream and end-of-packet strobe
//   pkt_count, new_flow_count
//                           statistics, live only with DPI_FEEDER_STATS_EN
//
// Build option
//   DPI_FEEDER_STATS_EN     builds the packet and flow-miss counters;
//                           when undefined, both outputs read 0.
module dpi_stream_feeder #(
   parameter int NUM_CAT = 16,
   parameter int KEY_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [KEY_W-1:0]   in_key,
   input  logic [31:0]        in_data,
   input  logic               in_valid,
   input  logic               in_sop,
   input  logic               in_eop,
   input  logic [1:0]         in_last_bytes,
   output logic               in_ready,
   input  logic               cfg_we,
   input  logic [5:0]         cfg_sid,
   input  logic [NUM_CAT-1:0] cfg_mask,
   output logic               load_state,
   output logic               new_stream_id,
   output logic [5:0]         stream_id,
   output logic [NUM_CAT-1:0] enable,
   output logic [7:0]         char_in,
   output logic               char_in_vld,
   output logic               eop,
   output logic [15:0]        pkt_count,
   output logic [15:0]        new_flow_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_LOAD, S_WAIT, S_STREAM, S_DRAIN, S_EOP
   } state_t;

   state_t state, state_nx;

   // current packet / word holding registers
   logic [KEY_W-1:0]   key_r;
   logic [31:0]        word_r;
   logic               weop_r;
   logic [1:0]         wlast_r;
   logic [1:0]         bidx;
   logic               have_word;

   // flow table
   logic [KEY_W-1:0]   tbl_key  [64];
   logic [63:0]        tbl_vld;
   logic [NUM_CAT-1:0] tbl_mask [64];
   logic [5:0]         alloc_ptr;

   // per-packet handshake registers
   logic               new_r;
   logic [5:0]         sid_r;
   logic [NUM_CAT-1:0] en_r;

   logic               hit;
   logic [5:0]         hit_idx;
   logic [1:0]         last_idx;
   logic               last_byte;

   // Keys are unique among valid entries, so the priority order only
   // matters for tie-breaking; the lowest index wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 63; i >= 0; i--) begin
         if (tbl_vld[i] && tbl_key[i] == key_r) begin
            hit     = 1'b1;
            hit_idx = 6'(i);
         end
      end
   end

   // Index of the final byte of the held word. in_last_bytes == 0 encodes
   // four bytes, which the 2-bit wrap of (0 - 1) maps to index 3.
   assign last_idx  = weop_r ? (wlast_r - 2'd1) : 2'd3;
   assign last_byte = (bidx == last_idx);

   always_comb begin
      state_nx    = state;
      in_ready    = 1'b0;
      load_state  = 1'b0;
      char_in_vld = 1'b0;
      eop         = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid && in_sop) state_nx = S_LOOKUP;
         end
         S_LOOKUP: state_nx = S_LOAD;
         S_LOAD: begin
            load_state = 1'b1;
            state_nx   = S_WAIT;
         end
         S_WAIT: state_nx = S_STREAM;
         S_STREAM: begin
            if (have_word) begin
               char_in_vld = 1'b1;
               if (last_byte) begin
                  if (weop_r) state_nx = S_DRAIN;
                  else        in_ready = 1'b1;   // next word chains with no gap
               end
            end else begin
               in_ready = 1'b1;                  // starved: take the next word
            end
         end
         S_DRAIN: state_nx = S_EOP;
         S_EOP: begin
            eop      = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      // Keep strobes and ready quiet while reset is held, whatever state
      // the FSM was left in.
      if (!rst_n) begin
         in_ready    = 1'b0;
         load_state  = 1'b0;
         char_in_vld = 1'b0;
         eop         = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         key_r     <= '0;
         word_r    <= '0;
         weop_r    <= 1'b0;
         wlast_r   <= '0;
         bidx      <= '0;
         have_word <= 1'b0;
         tbl_vld   <= '0;
         alloc_ptr <= '0;
         new_r     <= 1'b0;
         sid_r     <= '0;
         en_r      <= '0;
         for (int i = 0; i < 64; i++) tbl_mask[i] <= '1;
      end else begin
         state <= state_nx;
         if (cfg_we) tbl_mask[cfg_sid] <= cfg_mask;
         case (state)
            S_IDLE: begin
               if (in_valid && in_sop) begin
                  key_r     <= in_key;
                  word_r    <= in_data;
                  weop_r    <= in_eop;
                  wlast_r   <= in_last_bytes;
                  bidx      <= '0;
                  have_word <= 1'b1;
               end
            end
            // stream_id/enable are captured at the end of lookup so they are
            // already stable in the load_state cycle; the mask is sampled here,
            // so a cfg write lands on the following packet.
            S_LOOKUP: begin
               if (hit) begin
                  sid_r <= hit_idx;
                  en_r  <= tbl_mask[hit_idx];
                  new_r <= 1'b0;
               end else begin
                  sid_r              <= alloc_ptr;
                  en_r               <= tbl_mask[alloc_ptr];
                  new_r              <= 1'b1;
                  tbl_vld[alloc_ptr] <= 1'b1;
                  alloc_ptr          <= alloc_ptr + 6'd1;   // wraps 63 -> 0
               end
            end
            S_STREAM: begin
               if (have_word) begin
                  if (!last_byte) begin
                     bidx <= bidx + 2'd1;
                  end else if (!weop_r) begin
                     if (in_valid) begin
                        word_r  <= in_data;
                        weop_r  <= in_eop;
                        wlast_r <= in_last_bytes;
                        bidx    <= '0;
                     end else begin
                        have_word <= 1'b0;
                     end
                  end
               end else if (in_valid) begin
                  word_r    <= in_data;
                  weop_r    <= in_eop;
                  wlast_r   <= in_last_bytes;
                  bidx      <= '0;
                  have_word <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Key storage needs no reset: entries are qualified by tbl_vld.
   always_ff @(posedge clk) begin
      if (rst_n && state == S_LOOKUP && !hit) tbl_key[alloc_ptr] <= key_r;
   end

   always_comb begin
      char_in = '0;
      if (char_in_vld) begin
         case (bidx)
            2'd0:    char_in = word_r[31:24];
            2'd1:    char_in = word_r[23:16];
            2'd2:    char_in = word_r[15:8];
            default: char_in = word_r[7:0];
         endcase
      end
   end

   assign new_stream_id = load_state & new_r;
   assign stream_id     = sid_r;
   assign enable        = en_r;

`ifdef DPI_FEEDER_STATS_EN
   logic [15:0] pkt_cnt_r;
   logic [15:0] nf_cnt_r;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pkt_cnt_r <= '0;
         nf_cnt_r  <= '0;
      end else begin
         if (state == S_EOP)            pkt_cnt_r <= pkt_cnt_r + 16'd1;
         if (state == S_LOOKUP && !hit) nf_cnt_r  <= nf_cnt_r + 16'd1;
      end
   end
   assign pkt_count      = pkt_cnt_r;
   assign new_flow_count = nf_cnt_r;
`else
   assign pkt_count      = '0;
   assign new_flow_count = '0;
`endif

endmodule

// File: tb/tb_dpi_stream_feeder.sv
module tb_dpi_stream_feeder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] in_key = '0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
   logic [1:0]  in_last_bytes = '0;
   logic        in_ready;
   logic        cfg_we = 1'b0;
   logic [5:0]  cfg_sid = '0;
   logic [15:0] cfg_mask = '0;
   logic        load_state, new_stream_id, char_in_vld, eop;
   logic [5:0]  stream_id;
   logic [15:0] enable;
   logic [7:0]  char_in;
   logic [15:0] pkt_count, new_flow_count;

   dpi_stream_feeder dut (
      .clk(clk), .rst_n(rst_n),
      .in_key(in_key), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
      .in_eop(in_eop), .in_last_bytes(in_last_bytes), .in_ready(in_ready),
      .cfg_we(cfg_we), .cfg_sid(cfg_sid), .cfg_mask(cfg_mask),
      .load_state(load_state), .new_stream_id(new_stream_id), .stream_id(stream_id),
      .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
      .pkt_count(pkt_count), .new_flow_count(new_flow_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      int          kind;    // 0 load, 1 char, 2 eop
      logic [7:0]  ch;
      bit          nw;
      logic [5:0]  sid;
      logic [15:0] en;
      int          ecyc;    // required cycle, -1 when not pinned
   } ev_t;
   ev_t q[$];

   // ---------------- reference model ----------------
   int          id_of[int];       // key -> stream id
   int          key_at[64];
   bit          key_v[64];
   int          ptr;
   logic [15:0] mask_m[64];
   int          pkt_m, nf_m;
   logic [7:0]  pb[$];            // payload of the next packet

   function automatic void model_reset();
      id_of.delete();
      for (int i = 0; i < 64; i++) begin key_v[i] = 0; mask_m[i] = 16'hFFFF; end
      ptr = 0; pkt_m = 0; nf_m = 0;
   endfunction

   // Push all expected events of a packet whose sop word was accepted at cycle t.
   function automatic void model_pkt(input int key, input int t);
      ev_t e;
      int  sid;
      bit  nw;
      if (id_of.exists(key)) begin
         sid = id_of[key]; nw = 0;
      end else begin
         if (key_v[ptr]) id_of.delete(key_at[ptr]);
         key_at[ptr] = key; key_v[ptr] = 1; id_of[key] = ptr;
         sid = ptr; nw = 1; ptr = (ptr + 1) % 64; nf_m++;
      end
      e.kind = 0; e.ch = 0; e.nw = nw; e.sid = 6'(sid); e.en = mask_m[sid]; e.ecyc = t + 2;
      q.push_back(e);
      for (int i = 0; i < pb.size(); i++) begin
         e.kind = 1; e.ch = pb[i]; e.ecyc = (i == 0) ? t + 4 : -1;
         q.push_back(e);
      end
      e.kind = 2; e.ecyc = -1;
      q.push_back(e);
   endfunction

   // ---------------- monitor ----------------
   ev_t         me;
   int          pk;
   logic [5:0]  cur_sid;
   logic [15:0] cur_en;
   int          last_char_cyc;
   bit          ready_chk = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         ready_chk = 0;
      end else begin
         if (ready_chk) begin
            chk("ready_after_eop", in_ready, 1);
            ready_chk = 0;
         end
         if (load_state | char_in_vld | eop)
            chk("strobe_exclusive", 32'(load_state) + 32'(char_in_vld) + 32'(eop), 1);
         if (load_state) begin
            pk = (q.size() > 0) ? q[0].kind : 9;
            chk("load_expected", pk, 0);
            if (pk == 0) begin
               me = q.pop_front();
               chk("new_stream_id", new_stream_id, me.nw);
               chk("stream_id", stream_id, me.sid);
               chk("enable", enable, me.en);
               chk("load_cycle", cyc, me.ecyc);
               cur_sid = me.sid; cur_en = me.en;
            end
         end
         if (char_in_vld) begin
            pk = (q.size() > 0) ? q[0].kind : 9;
            chk("char_expected", pk, 1);
            if (pk == 1) begin
               me = q.pop_front();
               chk("char_in", char_in, me.ch);
               if (me.ecyc >= 0) chk("first_char_cycle", cyc, me.ecyc);
               chk("sid_held", stream_id, cur_sid);
               chk("enable_held", enable, cur_en);
            end
            last_char_cyc = cyc;
         end
         if (eop) begin
            pk = (q.size() > 0) ? q[0].kind : 9;
            chk("eop_expected", pk, 2);
            if (pk == 2) begin
               void'(q.pop_front());
               chk("eop_cycle", cyc, last_char_cyc + 2);
               chk("sid_held_eop", stream_id, cur_sid);
               pkt_m++;
            end
            ready_chk = 1;
         end
      end
   end

   // ---------------- driver ----------------
   // Called at posedge+1; returns at posedge+1 after the word was taken.
   task automatic send_word(input logic [31:0] d, input bit s, input bit e,
                            input logic [1:0] lb, input logic [15:0] k, output int acc);
      in_data = d; in_sop = s; in_eop = e; in_last_bytes = lb; in_key = k; in_valid = 1;
      acc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin acc = cyc; break; end
         @(posedge clk); #1;
      end
      if (acc < 0) chk("ready_timeout", 0, 1);
      else begin @(posedge clk); #1; end
      in_valid = 0; in_sop = 0; in_eop = 0;
   endtask

   task automatic do_reset();
      rst_n = 0; in_valid = 0; in_sop = 0; in_eop = 0; cfg_we = 0;
      q.delete(); model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_load_state", load_state, 0);
      chk("rst_new_stream_id", new_stream_id, 0);
      chk("rst_char_in_vld", char_in_vld, 0);
      chk("rst_eop", eop, 0);
      chk("rst_stream_id", stream_id, 0);
      chk("rst_char_in", char_in, 0);
      chk("rst_enable", enable, 0);
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_new_flow_count", new_flow_count, 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      chk("ready_after_reset", in_ready, 1);
      @(posedge clk); #1;
   endtask

   // gap: idle cycles before word 2 (>=0), or -1 for a random 0..3 before each later word.
   // abort: nonzero asserts reset while the first word is being streamed.
   task automatic send_pkt(input logic [15:0] key, input int gap, input bit abort);
      int          n, nwd, rem, acc, g;
      logic [31:0] d;
      logic [1:0]  lb;
      n = pb.size(); nwd = (n + 3) / 4;
      for (int w = 0; w < nwd; w++) begin
         d = $urandom;
         rem = n - 4 * w; if (rem > 4) rem = 4;
         for (int j = 0; j < rem; j++) d[31 - 8*j -: 8] = pb[4*w + j];
         lb = (rem == 4) ? 2'd0 : 2'(rem);
         g = (gap < 0) ? int'($urandom_range(0, 3)) : ((w == 1) ? gap : 0);
         if (w > 0 && g > 0) begin repeat (g) @(posedge clk); #1; end
         send_word(d, w == 0, w == nwd - 1, lb, key, acc);
         if (w == 0) begin
            model_pkt(key, acc);
            if (abort) begin
               repeat (4) @(posedge clk); #1;   // inside the byte stream of word 1
               do_reset();
               return;
            end
         end
      end
   endtask

   task automatic fill_pb(input int n);
      pb.delete();
      for (int i = 0; i < n; i++) pb.push_back(8'($urandom));
   endtask

   task automatic cfg_write(input logic [5:0] sid, input logic [15:0] m);
      cfg_we = 1; cfg_sid = sid; cfg_mask = m;
      mask_m[sid] = m;
      @(posedge clk); #1;
      cfg_we = 0;
   endtask

   initial begin
      model_reset();
      @(posedge clk); #1;
      do_reset();

      // single-word packet, new flow -> id 0
      pb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_pkt(16'h1234, 0, 0);
      // same flow, two valid bytes in the eop word
      pb = '{8'hAA, 8'hBB};
      send_pkt(16'h1234, 0, 0);

      // 64 more distinct keys: ids 1..63, then the last wraps onto id 0
      for (int i = 0; i < 64; i++) begin
         fill_pb($urandom_range(1, 5));
         send_pkt(16'(16'h2000 + i), 0, 0);
      end
      // 0x1234 was evicted: miss, gets id 1
      fill_pb(3);
      send_pkt(16'h1234, 0, 0);

      // 3-word packet, word 2 held back 3 cycles
      fill_pb(12);
      send_pkt(16'h1234, 3, 0);

      // mask change while a sid-0 packet is in flight
      fill_pb(8);
      send_pkt(16'h203F, 0, 0);
      cfg_write(6'd0, 16'h0005);
      fill_pb(4);
      send_pkt(16'h203F, 0, 0);

      // randomized traffic over a key pool larger than the table
      for (int p = 0; p < 40; p++) begin
         fill_pb($urandom_range(1, 12));
         send_pkt(16'(16'h3000 + $urandom_range(0, 79)), -1, 0);
         if ($urandom_range(0, 9) < 3) cfg_write(6'($urandom), 16'($urandom));
      end

      // drain before the abort so every completed packet is accounted
      for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
      chk("queue_drained_pre_abort", q.size(), 0);
      #1;

      // reset in the middle of a packet: no eop, table lost
      fill_pb(12);
      send_pkt(16'h4444, 0, 1);
      pb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      send_pkt(16'h1234, 0, 0);

      for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
      chk("queue_drained", q.size(), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
`ifdef DPI_FEEDER_STATS_EN
      chk("pkt_count", pkt_count, 32'(pkt_m));
      chk("new_flow_count", new_flow_count, 32'(nf_m));
`else
      chk("pkt_count_tied", pkt_count, 0);
      chk("new_flow_count_tied", new_flow_count, 0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
